rd_burst_seq: RTL

//  Upstream sequencer for the single-read FSM (ports start/ws in, rd/ds out).

---
 rtl/rd_burst_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/rd_burst_seq.sv
// rd_burst_seq: burst sequencer in front of the single-read FSM.
// Turns one (addr, len, wait) command into len start/ws handshakes and a done pulse.
module rd_burst_seq #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8,
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [WAIT_W-1:0] cmd_wait,
    output logic              start,
    output logic              ws,
    input  logic              rd,
    input  logic              ds,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [WAIT_W-1:0] wait_lat;
    logic [WAIT_W-1:0] wcnt;
    logic              phase;
    logic              accept, last_ds;
    logic              start_nxt, busy_nxt, done_nxt, err_nxt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_nxt = state;
        cmd_ready = (state == S_IDLE);
        accept    = cmd_valid && cmd_ready;
        ws        = (state == S_WAIT) && rd && phase && (wcnt != '0);
        last_ds   = (state == S_WAIT) && ds && (remaining == LEN_W'(1));

        case (state)
            S_IDLE:  if (accept && cmd_len != '0) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (ds) state_nxt = last_ds ? S_IDLE : S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase

        start_nxt = (state_nxt == S_ISSUE);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (accept && cmd_len == '0) || last_ds;
        // Protocol violations are only reported; sequencing carries on regardless.
        err_nxt   = err || (ds && state != S_WAIT) || (rd && state == S_IDLE) || (ds && rd);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            start <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            start <= start_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            wait_lat  <= '0;
            wcnt      <= '0;
            phase     <= 1'b0;
            rd_addr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        remaining <= cmd_len;
                        wait_lat  <= cmd_wait;
                        if (cmd_len != '0) rd_addr <= cmd_addr;
                    end
                end
                S_ISSUE: begin
                    wcnt  <= wait_lat;
                    phase <= 1'b0;
                end
                S_WAIT: begin
                    // phase tracks READ (0) / DLY (1) of the read FSM while rd is high.
                    if (rd) phase <= ~phase;
                    if (ws) wcnt <= wcnt - WAIT_W'(1);
                    if (ds) begin
                        remaining <= remaining - LEN_W'(1);
                        if (!last_ds) rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
